// File: rtl/axil_reg_master_if.sv
// AXI4-Lite bus bundle between the register master and a slave.
// Master drives address/data/valid, slave drives ready/response.
interface axil_reg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator: one single-word write or read per command,
// answered with a one-cycle response pulse; bus waits are time-limited.
module axil_reg_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  axil_reg_master_if.master m_axi
);

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RADDR, RDATA, RESP
  } state_t;

  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              aw_done;
  logic              w_done;
  logic [31:0]       cnt;

  logic aw_fin;
  logic w_fin;
  logic advance;
  logic in_bus;
  logic tmo;
  logic unused_resp;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign cmd_ready   = (state == IDLE);
  assign busy        = ~cmd_ready;
  assign unused_resp = ^{m_axi.bresp[0], m_axi.rresp[0]};

  assign aw_fin = aw_done | (awvalid_q & m_axi.awready);
  assign w_fin  = w_done  | (wvalid_q  & m_axi.wready);

  always_comb begin
    advance = 1'b0;
    in_bus  = 1'b0;
    unique case (state)
      WR: begin
        in_bus  = 1'b1;
        advance = aw_fin & w_fin;
      end
      WRESP: begin
        in_bus  = 1'b1;
        advance = bready_q & m_axi.bvalid;
      end
      RADDR: begin
        in_bus  = 1'b1;
        advance = arvalid_q & m_axi.arready;
      end
      RDATA: begin
        in_bus  = 1'b1;
        advance = rready_q & m_axi.rvalid;
      end
      default: ;
    endcase
  end

  // A completing handshake always wins over an expiring counter
  assign tmo = (TIMEOUT != 0) && (cnt == TLIM) && in_bus && !advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= cnt + 32'd1;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            if (cmd_write) begin
              state     <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.wready) wvalid_q <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            state    <= WRESP;
            bready_q <= 1'b1;
            cnt      <= '0;
          end
        end
        WRESP: begin
          if (bready_q && m_axi.bvalid) begin
            state     <= RESP;
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= m_axi.bresp[1];
            cnt       <= '0;
          end
        end
        RADDR: begin
          if (arvalid_q && m_axi.arready) begin
            state     <= RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt       <= '0;
          end
        end
        RDATA: begin
          if (rready_q && m_axi.rvalid) begin
            state     <= RESP;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= m_axi.rdata;
            rsp_err   <= m_axi.rresp[1];
            cnt       <= '0;
          end
        end
        RESP: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
      if (tmo) begin
        state     <= RESP;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_master.sv
// Bench for axil_reg_master: scripted AXI-Lite slave, response
// scoreboard fed by the stimulus and drained by a monitor.
module tb_axil_reg_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  axil_reg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_reg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_axi     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int nrsp = 0;

  int          aw_lat = 0;
  int          w_lat = 0;
  int          ar_lat = 0;
  int          r_lat = 1;
  logic        b_en = 1'b1;
  logic [1:0]  b_resp = 2'b00;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;
  logic        slv_clr = 1'b0;

  int          aw_c, w_c, ar_c, r_c, bready_c, w_unstable;
  logic        got_aw, got_w, got_ar;
  logic        pv_aw, pv_w, pv_ar, pv_b, pv_r;
  logic [31:0] pv_wdata, s_addr, s_wdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor and scripted slave share the falling edge
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (rsp_valid) begin
      nrsp = nrsp + 1;
      chk("rsp_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.lat >= 0) chk("rsp_lat", 32'(ncyc - e.t0), 32'(e.lat));
      end
    end
    if (rst || slv_clr) begin
      aw_c = 0; w_c = 0; ar_c = 0; r_c = 0;
      bready_c = 0; w_unstable = 0;
      got_aw = 0; got_w = 0; got_ar = 0;
      pv_aw = 0; pv_w = 0; pv_ar = 0; pv_b = 0; pv_r = 0;
      pv_wdata = '0; s_addr = '0; s_wdata = '0;
      bus.awready = 0; bus.wready = 0; bus.arready = 0;
      bus.bvalid = 0; bus.bresp = 2'b00;
      bus.rvalid = 0; bus.rdata = '0; bus.rresp = 2'b00;
    end else begin
      if (pv_aw && bus.awready) begin
        got_aw = 1; s_addr = bus.awaddr;
      end
      if (pv_w && bus.wready) begin
        got_w = 1; s_wdata = pv_wdata;
      end
      if (pv_b && bus.bvalid) begin
        bus.bvalid = 0; got_aw = 0; got_w = 0;
      end
      if (pv_ar && bus.arready) begin
        got_ar = 1; r_c = 0;
      end
      if (pv_r && bus.rvalid) begin
        bus.rvalid = 0; got_ar = 0;
      end
      if (bus.wvalid && pv_w && bus.wdata !== pv_wdata) w_unstable++;
      if (bus.awvalid) aw_c++;
      if (bus.wvalid) w_c++;
      if (bus.arvalid) ar_c++;
      if (bus.bready) bready_c++;
      bus.awready = bus.awvalid && (aw_c > aw_lat);
      bus.wready  = bus.wvalid && (w_c > w_lat);
      bus.arready = bus.arvalid && (ar_c > ar_lat);
      if (got_aw && got_w && b_en && !bus.bvalid) begin
        bus.bvalid = 1; bus.bresp = b_resp;
      end
      if (got_ar && !bus.rvalid) begin
        r_c++;
        if (r_c > r_lat) begin
          bus.rvalid = 1; bus.rdata = r_data; bus.rresp = r_resp;
        end
      end
    end
    pv_aw = bus.awvalid; pv_w = bus.wvalid; pv_wdata = bus.wdata;
    pv_ar = bus.arvalid; pv_b = bus.bready; pv_r = bus.rready;
  end

  task automatic sclr();
    @(negedge clk); #1 slv_clr = 1'b1;
    @(negedge clk); #1 slv_clr = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er,
                       input logic ee, input int lat);
    int n0;
    int k;
    @(negedge clk); #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    q.push_back('{er, ee, lat, ncyc});
    n0 = nrsp;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (nrsp == n0 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rsp_seen", 32'(nrsp), 32'(n0 + 1));
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 32'd0);
    chk("rst_readies", 32'({bus.bready, bus.rready}), 32'd0);
    rst = 1'b0;

    sclr();
    issue(1'b1, 32'h000, 32'h2, 32'h0, 1'b0, 3);
    chk("t1_wdata", s_wdata, 32'h2);
    chk("t1_addr", s_addr, 32'h000);
    chk("t1_bready_cycles", 32'(bready_c), 32'd1);

    sclr();
    w_lat = 3;
    issue(1'b1, 32'h000, 32'h2, 32'h0, 1'b0, 6);
    chk("t2_aw_cycles", 32'(aw_c), 32'd1);
    chk("t2_w_cycles", 32'(w_c), 32'd4);
    chk("t2_w_stable", 32'(w_unstable), 32'd0);
    chk("t2_wdata", s_wdata, 32'h2);
    w_lat = 0;

    sclr();
    aw_lat = 2;
    issue(1'b1, 32'h010, 32'h5A5A, 32'h0, 1'b0, 5);
    chk("t2b_aw_cycles", 32'(aw_c), 32'd3);
    chk("t2b_w_cycles", 32'(w_c), 32'd1);
    chk("t2b_addr", s_addr, 32'h010);
    chk("t2b_wdata", s_wdata, 32'h5A5A);
    aw_lat = 0;

    sclr();
    r_data = 32'hDEADBEEF; r_resp = 2'b00;
    issue(1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 4);

    sclr();
    r_data = 32'h12345678; r_resp = 2'b10;
    issue(1'b0, 32'h010, 32'h0, 32'h12345678, 1'b1, 4);
    r_resp = 2'b00;

    sclr();
    b_resp = 2'b10;
    issue(1'b1, 32'h000, 32'h1, 32'h0, 1'b1, 3);
    b_resp = 2'b00;

    sclr();
    b_en = 1'b0;
    issue(1'b1, 32'h000, 32'h7, 32'h0, 1'b1, 18);
    chk("t5_bready_cycles", 32'(bready_c), 32'd16);
    @(negedge clk); #1;
    chk("t5_bready_low", 32'(bus.bready), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    b_en = 1'b1;

    sclr();
    ar_lat = 100;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h010;
    n0 = nrsp;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    chk("t6_arvalid_up", 32'(bus.arvalid), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_arvalid_rst", 32'(bus.arvalid), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    ar_lat = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_no_rsp", 32'(nrsp), 32'(n0));

    sclr();
    r_data = 32'hCAFE0001;
    issue(1'b0, 32'h000, 32'h0, 32'hCAFE0001, 1'b0, 4);

    repeat (3) @(negedge clk);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
